// File: rtl/rob_ptr_ctrl.sv
// rob_ptr_ctrl: reorder-buffer allocation/retirement controller.
// Owns the circular head/tail pointers, the occupancy count and the per-entry
// valid/done bits. Flush and reset both return the buffer to the empty state.
module rob_ptr_ctrl #(
    parameter int ROB_ADDR_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rob_write_en,
    output logic                      rob_can_write,
    output logic [ROB_ADDR_WIDTH-1:0] rob_write_addr,
    input  logic                      wb_en,
    input  logic [ROB_ADDR_WIDTH-1:0] wb_addr,
    output logic                      rob_can_commit,
    output logic [ROB_ADDR_WIDTH-1:0] rob_commit_addr,
    input  logic                      rob_commit_en,
    input  logic                      flush,
    output logic [ROB_ADDR_WIDTH:0]   rob_count,
    output logic                      rob_empty
);

    localparam int DEPTH = 1 << ROB_ADDR_WIDTH;
    localparam logic [ROB_ADDR_WIDTH:0] DEPTH_C = (ROB_ADDR_WIDTH+1)'(DEPTH);

    logic [ROB_ADDR_WIDTH-1:0] r_head;
    logic [ROB_ADDR_WIDTH-1:0] r_tail;
    logic [ROB_ADDR_WIDTH:0]   r_count;
    logic [DEPTH-1:0]          r_valid;
    logic [DEPTH-1:0]          r_done;

    logic w_alloc;
    logic w_retire;

    // Status outputs come from registered state only; no bypass of space freed this cycle.
    always_comb begin
        rob_can_write   = (r_count < DEPTH_C);
        rob_write_addr  = r_tail;
        rob_commit_addr = r_head;
        rob_can_commit  = r_valid[r_head] && r_done[r_head];
        rob_count       = r_count;
        rob_empty       = (r_count == '0);
        w_alloc         = rob_write_en && rob_can_write;
        w_retire        = rob_commit_en && rob_can_commit;
    end

    // Pointer, count and entry-state update; reset/flush override everything.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
            r_done  <= '0;
        end else begin
            if (w_alloc) begin
                r_valid[r_tail] <= 1'b1;
                r_done[r_tail]  <= 1'b0;
                r_tail          <= r_tail + ROB_ADDR_WIDTH'(1);
            end
            // Gated on registered valid, so a writeback to the entry being
            // allocated this cycle is dropped.
            if (wb_en && r_valid[wb_addr]) begin
                r_done[wb_addr] <= 1'b1;
            end
            // Placed last so its clears win over a same-entry writeback set.
            if (w_retire) begin
                r_valid[r_head] <= 1'b0;
                r_done[r_head]  <= 1'b0;
                r_head          <= r_head + ROB_ADDR_WIDTH'(1);
            end
            case ({w_alloc, w_retire})
                2'b10:   r_count <= r_count + (ROB_ADDR_WIDTH+1)'(1);
                2'b01:   r_count <= r_count - (ROB_ADDR_WIDTH+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_rob_ptr_ctrl.sv
// Directed self-checking bench for rob_ptr_ctrl (default 16-entry configuration).
module tb_rob_ptr_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rob_write_en = 1'b0;
    logic       rob_can_write;
    logic [3:0] rob_write_addr;
    logic       wb_en = 1'b0;
    logic [3:0] wb_addr = '0;
    logic       rob_can_commit;
    logic [3:0] rob_commit_addr;
    logic       rob_commit_en = 1'b0;
    logic       flush = 1'b0;
    logic [4:0] rob_count;
    logic       rob_empty;

    int n_cmp  = 0;
    int n_fail = 0;

    rob_ptr_ctrl #(.ROB_ADDR_WIDTH(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .rob_write_en    (rob_write_en),
        .rob_can_write   (rob_can_write),
        .rob_write_addr  (rob_write_addr),
        .wb_en           (wb_en),
        .wb_addr         (wb_addr),
        .rob_can_commit  (rob_can_commit),
        .rob_commit_addr (rob_commit_addr),
        .rob_commit_en   (rob_commit_en),
        .flush           (flush),
        .rob_count       (rob_count),
        .rob_empty       (rob_empty)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic alloc_n(input int n);
        rob_write_en = 1'b1;
        for (int k = 0; k < n; k++) tick();
        rob_write_en = 1'b0;
    endtask

    task automatic wb(input logic [3:0] a);
        wb_en = 1'b1; wb_addr = a;
        tick();
        wb_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        n_cmp++; if (rob_can_write !== 1'b1) begin n_fail++; $display("FAIL reset_can_write got %0b want 1", rob_can_write); end
        n_cmp++; if (rob_write_addr !== 4'd0) begin n_fail++; $display("FAIL reset_write_addr got %0d want 0", rob_write_addr); end
        n_cmp++; if (rob_can_commit !== 1'b0) begin n_fail++; $display("FAIL reset_can_commit got %0b want 0", rob_can_commit); end
        n_cmp++; if (rob_commit_addr !== 4'd0) begin n_fail++; $display("FAIL reset_commit_addr got %0d want 0", rob_commit_addr); end
        n_cmp++; if (rob_count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", rob_count); end
        n_cmp++; if (rob_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %0b want 1", rob_empty); end
    endtask

    task automatic test_fill_to_full();
        rob_write_en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            n_cmp++; if (rob_count !== 5'(k + 1)) begin n_fail++; $display("FAIL fill_count[%0d] got %0d want %0d", k, rob_count, k + 1); end
        end
        n_cmp++; if (rob_can_write !== 1'b0) begin n_fail++; $display("FAIL full_can_write got %0b want 0", rob_can_write); end
        n_cmp++; if (rob_write_addr !== 4'd0) begin n_fail++; $display("FAIL full_write_addr got %0d want 0", rob_write_addr); end
        n_cmp++; if (rob_empty !== 1'b0) begin n_fail++; $display("FAIL full_empty got %0b want 0", rob_empty); end
        tick();  // 17th write while full
        rob_write_en = 1'b0;
        n_cmp++; if (rob_count !== 5'd16) begin n_fail++; $display("FAIL overfill_count got %0d want 16", rob_count); end
        n_cmp++; if (rob_write_addr !== 4'd0) begin n_fail++; $display("FAIL overfill_write_addr got %0d want 0", rob_write_addr); end
        do_flush();
    endtask

    task automatic test_out_of_order();
        alloc_n(4);
        n_cmp++; if (rob_write_addr !== 4'd4) begin n_fail++; $display("FAIL ooo_write_addr got %0d want 4", rob_write_addr); end
        wb(4'd2);
        n_cmp++; if (rob_can_commit !== 1'b0) begin n_fail++; $display("FAIL ooo_commit_after_wb2 got %0b want 0", rob_can_commit); end
        // Commit request while head not done must be ignored.
        rob_commit_en = 1'b1; tick(); rob_commit_en = 1'b0;
        n_cmp++; if (rob_count !== 5'd4) begin n_fail++; $display("FAIL ooo_ignored_commit_count got %0d want 4", rob_count); end
        n_cmp++; if (rob_commit_addr !== 4'd0) begin n_fail++; $display("FAIL ooo_ignored_commit_addr got %0d want 0", rob_commit_addr); end
        wb(4'd0);
        n_cmp++; if (rob_can_commit !== 1'b1) begin n_fail++; $display("FAIL ooo_commit_after_wb0 got %0b want 1", rob_can_commit); end
        n_cmp++; if (rob_commit_addr !== 4'd0) begin n_fail++; $display("FAIL ooo_commit_addr0 got %0d want 0", rob_commit_addr); end
        rob_commit_en = 1'b1; tick(); rob_commit_en = 1'b0;
        n_cmp++; if (rob_commit_addr !== 4'd1) begin n_fail++; $display("FAIL ooo_head_after_retire got %0d want 1", rob_commit_addr); end
        n_cmp++; if (rob_can_commit !== 1'b0) begin n_fail++; $display("FAIL ooo_commit_head1 got %0b want 0", rob_can_commit); end
        n_cmp++; if (rob_count !== 5'd3) begin n_fail++; $display("FAIL ooo_count_after_retire got %0d want 3", rob_count); end
        wb(4'd1);
        n_cmp++; if (rob_can_commit !== 1'b1) begin n_fail++; $display("FAIL ooo_commit_after_wb1 got %0b want 1", rob_can_commit); end
        do_flush();
    endtask

    task automatic test_wrap_around();
        logic [3:0] eh;
        logic [3:0] et;
        alloc_n(1);
        wb(4'd0);
        for (int i = 0; i < 20; i++) begin
            rob_write_en = 1'b1; rob_commit_en = 1'b1;
            tick();
            rob_write_en = 1'b0; rob_commit_en = 1'b0;
            eh = 4'((i + 1) % 16);
            et = 4'((i + 2) % 16);
            n_cmp++; if (rob_count !== 5'd1) begin n_fail++; $display("FAIL wrap_count[%0d] got %0d want 1", i, rob_count); end
            n_cmp++; if (rob_commit_addr !== eh) begin n_fail++; $display("FAIL wrap_head[%0d] got %0d want %0d", i, rob_commit_addr, eh); end
            n_cmp++; if (rob_write_addr !== et) begin n_fail++; $display("FAIL wrap_tail[%0d] got %0d want %0d", i, rob_write_addr, et); end
            wb(eh);
            n_cmp++; if (rob_can_commit !== 1'b1) begin n_fail++; $display("FAIL wrap_commit[%0d] got %0b want 1", i, rob_can_commit); end
        end
        do_flush();
    endtask

    task automatic test_full_with_retire();
        alloc_n(16);
        wb(4'd0);
        n_cmp++; if (rob_can_commit !== 1'b1) begin n_fail++; $display("FAIL fullret_can_commit got %0b want 1", rob_can_commit); end
        n_cmp++; if (rob_can_write !== 1'b0) begin n_fail++; $display("FAIL fullret_can_write_before got %0b want 0", rob_can_write); end
        rob_write_en = 1'b1; rob_commit_en = 1'b1;
        tick();
        rob_write_en = 1'b0; rob_commit_en = 1'b0;
        n_cmp++; if (rob_count !== 5'd15) begin n_fail++; $display("FAIL fullret_count got %0d want 15", rob_count); end
        n_cmp++; if (rob_can_write !== 1'b1) begin n_fail++; $display("FAIL fullret_can_write_after got %0b want 1", rob_can_write); end
        n_cmp++; if (rob_write_addr !== 4'd0) begin n_fail++; $display("FAIL fullret_write_addr got %0d want 0", rob_write_addr); end
        n_cmp++; if (rob_commit_addr !== 4'd1) begin n_fail++; $display("FAIL fullret_commit_addr got %0d want 1", rob_commit_addr); end
        do_flush();
    endtask

    task automatic test_flush_priority();
        alloc_n(5);
        wb(4'd0);
        flush = 1'b1; rob_write_en = 1'b1; wb_en = 1'b1; wb_addr = 4'd1; rob_commit_en = 1'b1;
        tick();
        flush = 1'b0; rob_write_en = 1'b0; wb_en = 1'b0; rob_commit_en = 1'b0;
        n_cmp++; if (rob_commit_addr !== 4'd0) begin n_fail++; $display("FAIL flush_head got %0d want 0", rob_commit_addr); end
        n_cmp++; if (rob_write_addr !== 4'd0) begin n_fail++; $display("FAIL flush_tail got %0d want 0", rob_write_addr); end
        n_cmp++; if (rob_count !== 5'd0) begin n_fail++; $display("FAIL flush_count got %0d want 0", rob_count); end
        n_cmp++; if (rob_empty !== 1'b1) begin n_fail++; $display("FAIL flush_empty got %0b want 1", rob_empty); end
        n_cmp++; if (rob_can_commit !== 1'b0) begin n_fail++; $display("FAIL flush_can_commit got %0b want 0", rob_can_commit); end
        wb(4'd3);  // stale writeback to a discarded entry
        n_cmp++; if (rob_count !== 5'd0) begin n_fail++; $display("FAIL stale_wb_count got %0d want 0", rob_count); end
        alloc_n(1);
        n_cmp++; if (rob_can_commit !== 1'b0) begin n_fail++; $display("FAIL post_flush_commit got %0b want 0", rob_can_commit); end
        n_cmp++; if (rob_count !== 5'd1) begin n_fail++; $display("FAIL post_flush_count got %0d want 1", rob_count); end
        // Mid-stream reset behaves like flush.
        alloc_n(2);
        rst = 1'b1; rob_write_en = 1'b1;
        tick();
        rst = 1'b0; rob_write_en = 1'b0;
        n_cmp++; if (rob_count !== 5'd0) begin n_fail++; $display("FAIL midrst_count got %0d want 0", rob_count); end
        n_cmp++; if (rob_write_addr !== 4'd0) begin n_fail++; $display("FAIL midrst_write_addr got %0d want 0", rob_write_addr); end
    endtask

    initial begin
        #2;
        test_reset();
        test_fill_to_full();
        test_out_of_order();
        test_wrap_around();
        test_full_with_retire();
        test_flush_priority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
